vga_draw_arbiter: RTL
=====================

Name: vga_draw_arbiter

Overview:
- Consumer end of the sprite pixel-writer interface. Several sprite engines (enemy, player, bullet) each present a pixel stream of x/y/colour plus a request.
- This block grants one source at a time using round-robin with burst locking.
- It forwards the accepted pixels, registered, to the single VGA adapter write port (x, y, colour, plot).
- It returns a per-source ack, so each writer advances only when its pixel is consumed.

Parameters:
- N_SRC, 4: number of pixel sources, 2..8.
- MAX_BURST, 160: maximum pixels accepted from one owner before forced rotation. Covers one full sprite block.
- SCREEN_W, 160: visible width in pixels. Used only with CLIP_EN.
- SCREEN_H, 120: visible height in pixels. Used only with CLIP_EN.

Ports:
- clk  in  1  system clock.
- reset_N  in  1  asynchronous, active-low reset.
- req  in  N_SRC  per-source pixel-valid request. Held high with stable data until acked.
- x_in  in  8*N_SRC  packed x coordinates. Source i occupies [8i+7:8i].
- y_in  in  7*N_SRC  packed y coordinates. Source i occupies [7i+6:7i].
- colour_in  in  3*N_SRC  packed colours. Source i occupies [3i+2:3i].
- ack  out  N_SRC  per-source accept, combinational. A pixel transfers on a clk edge where req[i] and ack[i] are both high.
- x_out  out  8  VGA write x.
- y_out  out  7  VGA write y.
- colour_out  out  3  VGA write colour.
- plot  out  1  VGA write enable.
- busy  out  1  high while in GRANT state.
- grant_id  out  3  index of the current or most recent owner.

Behaviour:
- Reset (asynchronous, reset_N low), all of the following take effect immediately:
  - state = IDLE, rr_ptr = 0, owner = 0, burst_cnt = 0.
  - plot = 0, x_out = 0, y_out = 0, colour_out = 0, ack = 0, busy = 0, grant_id = 0.
- Reset mid-burst: the burst is abandoned. A pixel on that edge is not forwarded. The source is expected to be reset by the same reset_N.
- State machine:
  - IDLE: ack = 0.
    - If any req bit is high, owner <= first i with req[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo N_SRC.
    - Also grant_id <= owner, burst_cnt <= 0, go to GRANT.
    - Otherwise stay in IDLE.
  - GRANT: ack[owner] = req[owner]; all other ack bits are 0.
    - On each transfer edge: capture the owner's x/y/colour into the output registers, set plot <= 1, burst_cnt <= burst_cnt + 1.
    - On a non-transfer edge: plot <= 0.
- Exit from GRANT to IDLE, with rr_ptr <= owner + 1 modulo N_SRC, when either of these holds:
  - req[owner] is 0 at the edge (source finished or paused).
  - A transfer occurs with burst_cnt == MAX_BURST-1 (forced rotation).
- Latency: a pixel accepted at edge k appears on x_out/y_out/colour_out with plot=1 during the cycle after edge k, i.e. one register stage.
- Maximum throughput: one pixel per clock within a burst. There is exactly one IDLE cycle between bursts.
- Outputs hold their last values when plot=0. colour_out is passed through unchanged; black pixels (erase) are ordinary writes.
- Fairness: with all sources requesting continuously, grants rotate 0,1,2,3,0,… Each grant lasts MAX_BURST pixels.
- Widths: burst_cnt is ceil(log2(MAX_BURST+1)) bits. Coordinates are not modified in any way (no wrap arithmetic).
- Request changes during a burst:
  - A source raising req during another's burst waits; no ack is issued to it.
  - A source dropping req without an ack loses nothing.

Optional Feature:
- Macro: VGA_DRAW_ARBITER_CLIP_EN.
- Defined: an accepted pixel with x_in >= SCREEN_W or y_in >= SCREEN_H is still acked and counted in burst_cnt, but plot stays 0 for it and the output registers keep their previous values. Sprites partly off-screen therefore never wrap onto the adapter.
- Undefined: every accepted pixel is forwarded unconditionally. SCREEN_W and SCREEN_H are unused.

Test Plan:
- Reset, then req=0001 with source 0 streaming (x=14, y=0, colour=3'b100) for 3 pixels, then dropping req. Required:
  - ack[0] high for 3 cycles.
  - plot high for 3 cycles, starting one cycle after the first ack.
  - Outputs match input order.
  - Returns to IDLE; rr_ptr = 1.
- req=1111 held continuously with MAX_BURST=4. Required:
  - grant_id sequence 0,1,2,3,0.
  - Each owner receives exactly 4 acks.
  - One idle cycle (plot=0, busy=0) between bursts.
- Source 2 streaming; source 1 raises req mid-burst. Required:
  - ack[1] stays 0 until source 2 drops req.
  - Next grant goes to source 3 only if source 3 is requesting, else to source 1.
- Source 0 deasserts req for 2 cycles mid-burst. Required:
  - Arbiter returns to IDLE and rr_ptr advances.
  - If source 0 is the only requester it is re-granted; no pixel is duplicated or lost.
- reset_N pulsed low asynchronously (between edges) during a burst. Required:
  - plot, ack and busy go to 0 immediately.
  - After release, state is IDLE and grant starts at source 0.
- CLIP_EN defined, pixels at x=158,159,160,161 with y=5. Required:
  - All 4 are acked.
  - plot pulses only for x=158 and 159.
  - x_out holds 159 afterward.

Source files
------------

// File: rtl/vga_draw_arbiter_if.sv
// Sprite pixel-writer bus shared by the draw arbiter and its sources.
//
// Source side (driven by the sprite engines):
//   req        per-source pixel-valid, held with stable data until acked
//   x_in       packed x coordinates, source i at [8i+7:8i]
//   y_in       packed y coordinates, source i at [7i+6:7i]
//   colour_in  packed colours, source i at [3i+2:3i]
//   ack        per-source accept (combinational, from the arbiter)
// Adapter side (driven by the arbiter):
//   x_out, y_out, colour_out, plot   registered VGA adapter write port
//   busy       high while a source owns the bus
//   grant_id   index of the current or most recent owner
//
// Modports: master = sources/adapter side, slave = arbiter.

interface vga_draw_arbiter_if #(
  parameter int unsigned N_SRC = 4
) ();

  logic [N_SRC-1:0]   req;
  logic [8*N_SRC-1:0] x_in;
  logic [7*N_SRC-1:0] y_in;
  logic [3*N_SRC-1:0] colour_in;
  logic [N_SRC-1:0]   ack;
  logic [7:0]         x_out;
  logic [6:0]         y_out;
  logic [2:0]         colour_out;
  logic               plot;
  logic               busy;
  logic [2:0]         grant_id;

  modport master (
    output req, x_in, y_in, colour_in,
    input  ack, x_out, y_out, colour_out, plot, busy, grant_id
  );

  modport slave (
    input  req, x_in, y_in, colour_in,
    output ack, x_out, y_out, colour_out, plot, busy, grant_id
  );

endinterface

// File: rtl/vga_draw_arbiter.sv
// Round-robin draw arbiter with burst locking. Grants one sprite source at a time,
// forwards its accepted pixels (one register stage) to the VGA adapter write port and
// returns a per-source ack so each writer only advances when its pixel is consumed.
//
// Ports:
//   clk      system clock
//   reset_N  asynchronous active-low reset
//   draw_io  vga_draw_arbiter_if.slave: source requests/data in, acks and
//            adapter write port (x_out, y_out, colour_out, plot), busy, grant_id out
//
// Optional feature: define VGA_DRAW_ARBITER_CLIP_EN to suppress plotting of accepted
// pixels with x >= SCREEN_W or y >= SCREEN_H (still acked and counted in the burst).

module vga_draw_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned MAX_BURST = 160,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120
) (
  input logic               clk,
  input logic               reset_N,
  vga_draw_arbiter_if.slave draw_io
);

  localparam int unsigned IdxW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  if (N_SRC < 2 || N_SRC > 8 || MAX_BURST < 1 || SCREEN_W < 1 || SCREEN_H < 1) begin : g_bad_cfg
    $error("vga_draw_arbiter: unsupported parameter set");
  end

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   rr_ptr_q;
  logic [IdxW-1:0]   owner_q;
  logic [CntW-1:0]   burst_cnt_q;
  logic              plot_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [2:0]        colour_q;
  logic [2:0]        grant_id_q;

  logic              found;
  logic [IdxW-1:0]   pick;
  logic [IdxW-1:0]   owner_nxt;
  logic              xfer;
  logic              last_beat;
  logic              on_screen;
  logic [7:0]        own_x;
  logic [6:0]        own_y;
  logic [2:0]        own_c;
  int unsigned       idx;

  // First requester at or after rr_ptr, wrapping modulo N_SRC.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      idx = (int'(rr_ptr_q) + i) % N_SRC;
      if (!found && draw_io.req[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    own_x     = draw_io.x_in[8*int'(owner_q) +: 8];
    own_y     = draw_io.y_in[7*int'(owner_q) +: 7];
    own_c     = draw_io.colour_in[3*int'(owner_q) +: 3];
    xfer      = (state_q == StGrant) && draw_io.req[owner_q];
    last_beat = (burst_cnt_q == CntW'(MAX_BURST - 1));
    owner_nxt = (owner_q == IdxW'(N_SRC - 1)) ? '0 : owner_q + IdxW'(1);
  end

`ifdef VGA_DRAW_ARBITER_CLIP_EN
  assign on_screen = (int'(own_x) < int'(SCREEN_W)) && (int'(own_y) < int'(SCREEN_H));
`else
  assign on_screen = 1'b1;
`endif

  // Only the owner can be acked; its ack simply mirrors its request.
  always_comb begin
    draw_io.ack = '0;
    if (state_q == StGrant) begin
      draw_io.ack[owner_q] = draw_io.req[owner_q];
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
      plot_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      grant_id_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          plot_q <= 1'b0;
          if (found) begin
            owner_q     <= pick;
            grant_id_q  <= 3'(pick);
            burst_cnt_q <= '0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          if (xfer) begin
            burst_cnt_q <= burst_cnt_q + CntW'(1);
            plot_q      <= on_screen;
            if (on_screen) begin
              x_q      <= own_x;
              y_q      <= own_y;
              colour_q <= own_c;
            end
            // Forced rotation after a full burst.
            if (last_beat) begin
              state_q  <= StIdle;
              rr_ptr_q <= owner_nxt;
            end
          end else begin
            // Owner finished or paused: release the bus.
            plot_q   <= 1'b0;
            state_q  <= StIdle;
            rr_ptr_q <= owner_nxt;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign draw_io.x_out      = x_q;
  assign draw_io.y_out      = y_q;
  assign draw_io.colour_out = colour_q;
  assign draw_io.plot       = plot_q;
  assign draw_io.busy       = (state_q == StGrant);
  assign draw_io.grant_id   = grant_id_q;

endmodule
